perf_monitor: RTL

- Synthesizable performance/retire monitor beside the processor's writeback and cache stages.
- Consumes per-cycle retire and cache strobes and keeps cycle, instruction and I/D-cache request/hit counts.
- On halt it freezes the counts and streams them out over a valid/ready dump port to a host or logger.

---
 rtl/perf_monitor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/perf_monitor.sv
// Retire/cache performance monitor: counts cycles, instructions and I/D-cache traffic,
// then streams the frozen counts over a valid/ready dump port on halt. Optional PERF_SAT_EN.
module perf_monitor #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             reg_wrt,
  input  logic             mem_wrt,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [2:0]       dump_idx,
  output logic [CNT_W-1:0] dump_data,
  output logic             done,
  output logic             proto_err
);

  localparam int NUM_CNT = 6;
`ifdef PERF_SAT_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  typedef enum logic [1:0] {
    S_COUNT,
    S_DUMP,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [CNT_W-1:0] cnt_d [NUM_CNT];
  logic             inc   [NUM_CNT];
  logic [2:0]       nxt_idx;
  logic [CNT_W-1:0] next_word;
  logic             bad_hit;
`ifdef PERF_SAT_EN
  logic [NUM_CNT-1:0] sat_q;
  logic [NUM_CNT-1:0] sat_d;
`endif

  assign bad_hit = (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    inc[0] = 1'b1;
    inc[1] = halt | reg_wrt | mem_wrt;
    inc[2] = icache_req;
    inc[3] = icache_hit & icache_req;
    inc[4] = dcache_req;
    inc[5] = dcache_hit & dcache_req;
`ifdef PERF_SAT_EN
    sat_d = sat_q;
`endif
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        // A halt on the clear cycle still counts itself as one cycle and one instruction.
        cnt_d[i] = (halt && i < 2) ? CNT_W'(1) : '0;
`ifdef PERF_SAT_EN
        sat_d[i] = 1'b0;
`endif
      end else if (inc[i]) begin
`ifdef PERF_SAT_EN
        if (&cnt_q[i]) sat_d[i] = 1'b1;
        else           cnt_d[i] = cnt_q[i] + CNT_W'(1);
`else
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
`endif
      end
    end
  end

  // Word presented after the current one is accepted.
  always_comb begin
    nxt_idx   = dump_idx + 3'd1;
    next_word = '0;
    if (nxt_idx < 3'(NUM_CNT)) begin
      next_word = cnt_q[nxt_idx];
    end
`ifdef PERF_SAT_EN
    else if (nxt_idx == 3'd6) begin
      next_word = CNT_W'(sat_q);
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_COUNT;
      // NOTE: the counter array is a bank of flops, not a RAM, so it is reset like any other register.
      cnt_q      <= '{default: '0};
`ifdef PERF_SAT_EN
      sat_q      <= '0;
`endif
      dump_valid <= 1'b0;
      dump_idx   <= 3'd0;
      dump_data  <= '0;
      done       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        S_COUNT: begin
          cnt_q <= cnt_d;
`ifdef PERF_SAT_EN
          sat_q <= sat_d;
`endif
          if (bad_hit) proto_err <= 1'b1;
          if (halt) begin
            state      <= S_DUMP;
            dump_valid <= 1'b1;
            dump_idx   <= 3'd0;
            dump_data  <= cnt_d[0];
          end
        end
        S_DUMP: begin
          if (dump_ready) begin
            if (dump_idx == LAST_IDX) begin
              state      <= S_DONE;
              dump_valid <= 1'b0;
              dump_idx   <= 3'd0;
              dump_data  <= '0;
              done       <= 1'b1;
            end else begin
              dump_idx  <= nxt_idx;
              dump_data <= next_word;
            end
          end
        end
        S_DONE: begin
          dump_valid <= 1'b0;
          done       <= 1'b1;
        end
        default: state <= S_COUNT;
      endcase
    end
  end

endmodule
